// File: rtl/vga_pkg.sv
// Shared VGA pixel-path constants and the timing bundle type.
// Used by draw_char_rect_16x16 and vga_timing_delay.
package vga_pkg;

  localparam int RGB_W     = 12;
  localparam int HC_W      = 11;
  localparam int CHAR_W    = 8;
  localparam int CHAR_H    = 16;
  localparam int TEXT_COLS = 16;
  localparam int TEXT_ROWS = 16;
  localparam int FONT_AW   = 11;

  localparam int RECT_W = CHAR_W * TEXT_COLS;
  localparam int RECT_H = CHAR_H * TEXT_ROWS;

  typedef struct packed {
    logic [HC_W-1:0]  hcount;
    logic [HC_W-1:0]  vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;
  } vga_t;

endpackage

// File: rtl/vga_timing_delay.sv
// N-stage register for the VGA timing bundle; the last stage's rgb
// is loaded from rgb_next so the caller can substitute the overlaid pixel.
// Ports: pclk, rst_n, d (bundle in), rgb_next, q (bundle out),
//        rgb_mid / blank_mid (stage N-2 taps feeding pixel selection).
module vga_timing_delay
  import vga_pkg::*;
#(
  parameter int N = 2
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  vga_t             d,
  input  logic [RGB_W-1:0] rgb_next,
  output vga_t             q,
  output logic [RGB_W-1:0] rgb_mid,
  output logic             blank_mid
);

  vga_t pipe [N];

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '{default: '0};
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < N; i++) begin
        pipe[i] <= pipe[i-1];
      end
      pipe[N-1].rgb <= rgb_next;
    end
  end

  assign q         = pipe[N-1];
  assign rgb_mid   = pipe[N-2].rgb;
  assign blank_mid = pipe[N-2].hblnk | pipe[N-2].vblnk;

endmodule

// File: rtl/draw_char_rect_16x16.sv
// Overlays a 16x16 text map (8x16 glyphs) onto the VGA stream, 2-cycle latency.
// Ports: pclk, rst_n, *_in timing/rgb, char_yx/char_code map lookup,
//        font_addr/char_pixels font ROM, *_out timing/rgb.
// Macro DRAW_CHAR_BG_EN: clear glyph pixels take BG_COLOR (opaque box).
module draw_char_rect_16x16
  import vga_pkg::*;
#(
  parameter logic [HC_W-1:0]  XPOS       = '0,
  parameter logic [HC_W-1:0]  YPOS       = '0,
  parameter logic [RGB_W-1:0] TEXT_COLOR = 12'hFFF,
  parameter logic [RGB_W-1:0] BG_COLOR   = 12'h000
) (
  input  logic               pclk,
  input  logic               rst_n,
  input  logic [HC_W-1:0]    hcount_in,
  input  logic [HC_W-1:0]    vcount_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               hblnk_in,
  input  logic               vblnk_in,
  input  logic [RGB_W-1:0]   rgb_in,
  output logic [7:0]         char_yx,
  input  logic [6:0]         char_code,
  output logic [FONT_AW-1:0] font_addr,
  input  logic [7:0]         char_pixels,
  output logic [HC_W-1:0]    hcount_out,
  output logic [HC_W-1:0]    vcount_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               hblnk_out,
  output logic               vblnk_out,
  output logic [RGB_W-1:0]   rgb_out
);

`ifdef DRAW_CHAR_BG_EN
  localparam bit BG_EN = 1'b1;
`else
  localparam bit BG_EN = 1'b0;
`endif

  // One extra bit so a rectangle past the screen edge cannot wrap.
  localparam logic [HC_W:0] X0 = {1'b0, XPOS};
  localparam logic [HC_W:0] Y0 = {1'b0, YPOS};
  localparam logic [HC_W:0] X1 = X0 + (HC_W+1)'(RECT_W);
  localparam logic [HC_W:0] Y1 = Y0 + (HC_W+1)'(RECT_H);

  logic [6:0]       rx;
  logic [7:0]       ry;
  logic [HC_W:0]    h_ext;
  logic [HC_W:0]    v_ext;
  logic             in_rect;

  logic [6:0]       char_code_q;
  logic [3:0]       line_q;
  logic [2:0]       bit_q;
  logic             in_rect_q;

  vga_t             bundle_in;
  vga_t             bundle_out;
  logic [RGB_W-1:0] rgb_q;
  logic             blank_q;
  logic [RGB_W-1:0] rgb_next;

  // Only the low bits of the offsets are ever used.
  assign rx    = hcount_in[6:0] - XPOS[6:0];
  assign ry    = vcount_in[7:0] - YPOS[7:0];
  assign h_ext = {1'b0, hcount_in};
  assign v_ext = {1'b0, vcount_in};

  assign in_rect = (h_ext >= X0) && (h_ext < X1) &&
                   (v_ext >= Y0) && (v_ext < Y1);

  assign char_yx = {ry[7:4], rx[6:3]};

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      char_code_q <= '0;
      line_q      <= '0;
      bit_q       <= '0;
      in_rect_q   <= 1'b0;
    end else begin
      char_code_q <= char_code;
      line_q      <= ry[3:0];
      bit_q       <= rx[2:0];
      in_rect_q   <= in_rect;
    end
  end

  assign font_addr = {char_code_q, line_q};

  assign bundle_in = '{
    hcount: hcount_in,
    vcount: vcount_in,
    hsync:  hsync_in,
    vsync:  vsync_in,
    hblnk:  hblnk_in,
    vblnk:  vblnk_in,
    rgb:    rgb_in
  };

  // Bit 7 of the glyph row is the leftmost pixel.
  always_comb begin
    rgb_next = rgb_q;
    if (blank_q) begin
      rgb_next = '0;
    end else if (in_rect_q && char_pixels[3'd7 - bit_q]) begin
      rgb_next = TEXT_COLOR;
    end else if (in_rect_q && BG_EN) begin
      rgb_next = BG_COLOR;
    end
  end

  vga_timing_delay #(
    .N(2)
  ) u_delay (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .d         (bundle_in),
    .rgb_next  (rgb_next),
    .q         (bundle_out),
    .rgb_mid   (rgb_q),
    .blank_mid (blank_q)
  );

  assign hcount_out = bundle_out.hcount;
  assign vcount_out = bundle_out.vcount;
  assign hsync_out  = bundle_out.hsync;
  assign vsync_out  = bundle_out.vsync;
  assign hblnk_out  = bundle_out.hblnk;
  assign vblnk_out  = bundle_out.vblnk;
  assign rgb_out    = bundle_out.rgb;

endmodule

// File: tb/tb_draw_char_rect_16x16.sv
// Self-checking bench for draw_char_rect_16x16: directed vector table,
// hand sequences for latency/reset, and random stimulus against a model.
module tb_draw_char_rect_16x16;

  localparam logic [10:0] XP = 11'd100;
  localparam logic [10:0] YP = 11'd50;
  localparam logic [11:0] TC = 12'hABC;
  localparam logic [11:0] BC = 12'h00F;
`ifdef DRAW_CHAR_BG_EN
  localparam bit BG_EN = 1'b1;
`else
  localparam bit BG_EN = 1'b0;
`endif

  logic        pclk, rst_n;
  logic [10:0] hcount_in, vcount_in, hcount_out, vcount_out;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_in, rgb_out;
  logic [7:0]  char_yx;
  logic [6:0]  char_code;
  logic [10:0] font_addr;
  logic [7:0]  char_pixels;

  logic [7:0]  rom [2048];
  logic [6:0]  cmap [256];
  logic        force_en;
  logic [7:0]  force_val;

  assign char_code   = cmap[char_yx];
  assign char_pixels = force_en ? force_val : rom[font_addr];

  draw_char_rect_16x16 #(
    .XPOS(XP), .YPOS(YP), .TEXT_COLOR(TC), .BG_COLOR(BC)
  ) dut (
    .pclk(pclk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .char_yx(char_yx), .char_code(char_code),
    .font_addr(font_addr), .char_pixels(char_pixels),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
  } pix_t;

  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    logic        hb;
    logic        vb;
    logic [7:0]  g;
    logic [11:0] rgb;
    logic [11:0] exp;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  pix_t expq [$];
  logic        fa_valid;
  logic [10:0] fa_exp;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit in_rect(input pix_t p);
    int rx, ry;
    rx = int'(p.hc) - int'(XP);
    ry = int'(p.vc) - int'(YP);
    return rx >= 0 && rx < 128 && ry >= 0 && ry < 256;
  endfunction

  // Expected output pixel from the text-map / font rules.
  function automatic pix_t model(input pix_t p);
    pix_t o;
    int rx, ry, code;
    logic [7:0] g;
    o  = p;
    rx = int'(p.hc) - int'(XP);
    ry = int'(p.vc) - int'(YP);
    if (p.hb || p.vb) begin
      o.rgb = 12'h000;
    end else if (in_rect(p)) begin
      code = int'(cmap[(ry / 16) * 16 + rx / 8]);
      g = rom[code * 16 + ry % 16];
      if (g[7 - rx % 8]) o.rgb = TC;
      else if (BG_EN) o.rgb = BC;
    end
    return o;
  endfunction

  function automatic logic [63:0] outs();
    pix_t a;
    a = {hcount_out, vcount_out, hsync_out, vsync_out,
         hblnk_out, vblnk_out, rgb_out};
    return 64'(a);
  endfunction

  task automatic drive(input pix_t p);
    hcount_in = p.hc;
    vcount_in = p.vc;
    hsync_in  = p.hs;
    vsync_in  = p.vs;
    hblnk_in  = p.hb;
    vblnk_in  = p.vb;
    rgb_in    = p.rgb;
  endtask

  function automatic pix_t rand_pix();
    pix_t p;
    if ($urandom_range(1, 0) == 1) begin
      p.hc = 11'($urandom_range(240, 80));
      p.vc = 11'($urandom_range(320, 30));
    end else begin
      p.hc = 11'($urandom_range(2047, 0));
      p.vc = 11'($urandom_range(2047, 0));
    end
    p.hs  = 1'($urandom);
    p.vs  = 1'($urandom);
    p.hb  = ($urandom_range(7, 0) == 0);
    p.vb  = ($urandom_range(7, 0) == 0);
    p.rgb = 12'($urandom);
    return p;
  endfunction

  // One random cycle: check outputs, then present a new pixel.
  task automatic rand_cycle();
    pix_t p, e;
    int rx, ry;
    @(posedge pclk);
    #1;
    e = '0;
    if (expq.size() >= 2) e = expq.pop_front();
    chk("pipe", outs(), 64'(e));
    if (fa_valid) chk("font_addr", 64'(font_addr), 64'(fa_exp));
    p = rand_pix();
    drive(p);
    #1;
    rx = int'(p.hc) - int'(XP);
    ry = int'(p.vc) - int'(YP);
    fa_valid = in_rect(p);
    if (fa_valid) begin
      chk("char_yx", 64'(char_yx), 64'((ry / 16) * 16 + rx / 8));
      fa_exp = {cmap[(ry / 16) * 16 + rx / 8], 4'(ry % 16)};
    end
    expq.push_back(model(p));
  endtask

  vec_t vt [13];

  initial begin
    pix_t p;
    for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) cmap[i] = 7'($urandom);
    force_en  = 1'b0;
    force_val = 8'h00;
    fa_valid  = 1'b0;

    vt[0]  = '{11'd100, 11'd50,  0, 0, 8'h80, 12'h123, TC};
    vt[1]  = '{11'd101, 11'd50,  0, 0, 8'h80, 12'h456,
               BG_EN ? BC : 12'h456};
    vt[2]  = '{11'd227, 11'd60,  0, 0, 8'h01, 12'h111, TC};
    vt[3]  = '{11'd228, 11'd60,  0, 0, 8'hFF, 12'h789, 12'h789};
    vt[4]  = '{11'd99,  11'd60,  0, 0, 8'hFF, 12'h321, 12'h321};
    vt[5]  = '{11'd150, 11'd305, 0, 0, 8'hFF, 12'h222, TC};
    vt[6]  = '{11'd150, 11'd306, 0, 0, 8'hFF, 12'h654, 12'h654};
    vt[7]  = '{11'd100, 11'd49,  0, 0, 8'hFF, 12'h0C0, 12'h0C0};
    vt[8]  = '{11'd100, 11'd50,  1, 0, 8'hFF, 12'h777, 12'h000};
    vt[9]  = '{11'd300, 11'd50,  0, 1, 8'hFF, 12'h777, 12'h000};
    vt[10] = '{11'd121, 11'd83,  0, 0, 8'h04, 12'h333, TC};
    vt[11] = '{11'd121, 11'd83,  0, 0, 8'hFB, 12'h0F0,
               BG_EN ? BC : 12'h0F0};
    vt[12] = '{11'd100, 11'd50,  0, 0, 8'h00, 12'h5A5,
               BG_EN ? BC : 12'h5A5};

    // Reset with random inputs: all outputs held at zero.
    rst_n = 1'b0;
    drive(rand_pix());
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk);
      #1;
      chk("reset", outs(), 64'h0);
      drive(rand_pix());
    end
    @(posedge pclk);
    #1;
    rst_n = 1'b1;
    expq.delete();
    p = rand_pix();
    drive(p);
    expq.push_back(model(p));
    for (int i = 0; i < 400; i++) rand_cycle();

    // Mid-frame reset clears the pipeline immediately.
    @(posedge pclk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst", outs(), 64'h0);
    for (int i = 0; i < 2; i++) begin
      @(posedge pclk);
      #1;
      chk("rst_hold", outs(), 64'h0);
      drive(rand_pix());
    end
    @(posedge pclk);
    #1;
    rst_n = 1'b1;
    expq.delete();
    fa_valid = 1'b0;
    p = rand_pix();
    drive(p);
    expq.push_back(model(p));
    for (int i = 0; i < 300; i++) rand_cycle();

    // Directed table with a forced glyph row.
    force_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      force_val = vt[i].g;
      p = '{vt[i].h, vt[i].v, 1'b0, 1'b0, vt[i].hb, vt[i].vb, vt[i].rgb};
      drive(p);
      repeat (2) @(posedge pclk);
      #1;
      chk($sformatf("vec%0d", i), 64'(rgb_out), 64'(vt[i].exp));
    end
    force_en = 1'b0;

    // Index mapping: (117,83) -> row 2, col 2, line 1.
    drive('{11'd117, 11'd83, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000});
    #1;
    chk("idx_yx", 64'(char_yx), 64'h22);
    @(posedge pclk);
    #1;
    chk("idx_font", 64'(font_addr), 64'({cmap[8'h22], 4'd1}));

    // Single-cycle hsync pulse emerges exactly two cycles later.
    drive('{11'd900, 11'd900, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000});
    repeat (2) @(posedge pclk);
    #1;
    hsync_in = 1'b1;
    @(posedge pclk);
    #1;
    chk("lat_e1", 64'(hsync_out), 64'h0);
    hsync_in = 1'b0;
    @(posedge pclk);
    #1;
    chk("lat_e2", 64'(hsync_out), 64'h1);
    @(posedge pclk);
    #1;
    chk("lat_e3", 64'(hsync_out), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
